// File: rtl/fpu_wb_write_checker.sv
// Wishbone write-checker for the FPU slave: follows the firmware checkbits protocol and
// verifies that every acknowledged register write is reflected in the FPU register values.
module fpu_wb_write_checker #(
  parameter int unsigned         NUM_REGS       = 4,
  parameter int unsigned         DATA_W         = 32,
  parameter logic [31:0]         ADDR_BASE      = 32'h3000_0000,
  parameter logic [8*NUM_REGS-1:0] REG_OFFSETS  = {8'h24, 8'h1C, 8'h04, 8'h00},
  parameter logic [NUM_REGS-1:0] REQ_MASK       = 4'b1111,
  parameter int unsigned         CHECK_DELAY    = 2,
  parameter logic [15:0]         START_CODE     = 16'hAB60,
  parameter logic [15:0]         PASS_CODE      = 16'hAB61,
  parameter logic [15:0]         FINISH_CODE    = 16'hAB62,
  parameter int unsigned         TIMEOUT_CYCLES = 30000,
  localparam int unsigned        IdxW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic                       wbs_ack_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [DATA_W-1:0]          wbs_dat_i,
  input  logic [NUM_REGS*DATA_W-1:0] reg_val_i,
  input  logic [15:0]                checkbits_i,
  output logic [1:0]                 state_o,
  output logic [15:0]                test_cnt_o,
  output logic [15:0]                pass_cnt_o,
  output logic [15:0]                fail_cnt_o,
  output logic [NUM_REGS-1:0]        regs_seen_o,
  output logic [NUM_REGS-1:0]        mismatch_vec_o,
  output logic                       mismatch_o,
  output logic [IdxW-1:0]            mismatch_idx_o,
  output logic                       all_done_o,
  output logic                       timeout_o
);

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDrain = 2'd2, StDone = 2'd3} state_e;

  state_e                            state_q, state_d;
  logic [15:0]                       prev_cb_q;
  logic [NUM_REGS-1:0][3:0]          timer_q, timer_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]   shadow_q, shadow_d;
  logic [NUM_REGS-1:0]               seen_q, seen_d, mvec_q, mvec_d;
  logic [15:0]                       test_q, test_d, pass_q, pass_d, fail_q, fail_d;
  logic [19:0]                       tcnt_q, tcnt_d;
  logic                              mis_q, mis_d, done_q, done_d, to_q, to_d;
  logic [IdxW-1:0]                   idx_q, idx_d;

  logic                ev_start, ev_pass, ev_finish, wr_hs, active, pending, pass_ok;
  logic                new_test, do_eval, pass_inc, fail_inc;
  logic [NUM_REGS-1:0] hs_vec, fail_now, mvec_cmp;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Edge-detect codes so a word held on checkbits counts only once.
  assign ev_start  = (checkbits_i == START_CODE) && (prev_cb_q != START_CODE);
  assign ev_pass   = (checkbits_i == PASS_CODE) && (prev_cb_q != PASS_CODE);
  assign ev_finish = (checkbits_i == FINISH_CODE) && (prev_cb_q != FINISH_CODE);
  assign wr_hs     = wbs_cyc_i & wbs_stb_i & wbs_we_i & wbs_ack_i;

  always_comb begin
    hs_vec = '0;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      hs_vec[k] = wr_hs && (wbs_adr_i == ADDR_BASE + 32'(REG_OFFSETS[8*k +: 8]));
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    shadow_d = shadow_q;
    seen_d   = seen_q;
    test_d   = test_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    tcnt_d   = tcnt_q;
    done_d   = done_q;
    to_d     = to_q;
    idx_d    = idx_q;
    mis_d    = 1'b0;
    fail_now = '0;
    pending  = 1'b0;
    new_test = 1'b0;
    do_eval  = 1'b0;
    pass_inc = 1'b0;
    fail_inc = 1'b0;
    active   = (state_q == StRun) || (state_q == StDrain);

    // A timer at 1 expires this cycle: compare the shadow against the live register.
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      if (timer_q[k] != 4'd0) pending = 1'b1;
      if (active && (timer_q[k] != 4'd0)) begin
        timer_d[k] = timer_q[k] - 4'd1;
        if ((timer_q[k] == 4'd1) && (shadow_q[k] != reg_val_i[k*DATA_W +: DATA_W])) begin
          fail_now[k] = 1'b1;
        end
      end
    end
    mvec_cmp = mvec_q | fail_now;
    mvec_d   = mvec_cmp;
    if (|fail_now) begin
      mis_d = 1'b1;
      for (int k = int'(NUM_REGS) - 1; k >= 0; k--) begin
        if (fail_now[k]) idx_d = IdxW'(k);
      end
    end
    pass_ok = (mvec_cmp == '0) && ((seen_q & REQ_MASK) == REQ_MASK);

    if (state_q != StDone) begin
      tcnt_d = tcnt_q + 20'd1;
      if (ev_finish) begin
        do_eval = (state_q == StDrain);
        done_d  = 1'b1;
        state_d = StDone;
      end else if (tcnt_d == 20'(TIMEOUT_CYCLES)) begin
        to_d    = 1'b1;
        state_d = StDone;
      end else begin
        unique case (state_q)
          StIdle: new_test = ev_start;
          StRun: begin
            if (ev_start) begin
              fail_inc = 1'b1;
              new_test = 1'b1;
            end else begin
              if (ev_pass) begin
                if (pending) state_d = StDrain;
                else         do_eval = 1'b1;
              end
              for (int k = 0; k < int'(NUM_REGS); k++) begin
                if (hs_vec[k]) begin
                  shadow_d[k] = wbs_dat_i;
                  seen_d[k]   = 1'b1;
                  timer_d[k]  = 4'(CHECK_DELAY);
                end
              end
            end
          end
          StDrain: do_eval = !pending;
          default: ;
        endcase
      end
    end

    if (do_eval) begin
      if (pass_ok) pass_inc = 1'b1;
      else         fail_inc = 1'b1;
      if (!ev_finish) state_d = StIdle;
    end
    if (new_test) begin
      state_d = StRun;
      test_d  = sat_inc(test_q);
      seen_d  = '0;
      mvec_d  = '0;
      timer_d = '0;
    end
    if (pass_inc) pass_d = sat_inc(pass_q);
    if (fail_inc) fail_d = sat_inc(fail_q);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      prev_cb_q <= '0;
      timer_q   <= '0;
      shadow_q  <= '0;
      seen_q    <= '0;
      mvec_q    <= '0;
      test_q    <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      tcnt_q    <= '0;
      mis_q     <= 1'b0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_cb_q <= checkbits_i;
      timer_q   <= timer_d;
      shadow_q  <= shadow_d;
      seen_q    <= seen_d;
      mvec_q    <= mvec_d;
      test_q    <= test_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      tcnt_q    <= tcnt_d;
      mis_q     <= mis_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      to_q      <= to_d;
    end
  end

  assign state_o        = state_q;
  assign test_cnt_o     = test_q;
  assign pass_cnt_o     = pass_q;
  assign fail_cnt_o     = fail_q;
  assign regs_seen_o    = seen_q;
  assign mismatch_vec_o = mvec_q;
  assign mismatch_o     = mis_q;
  assign mismatch_idx_o = idx_q;
  assign all_done_o     = done_q;
  assign timeout_o      = to_q;

endmodule

// File: tb/tb_fpu_wb_write_checker.sv
// Bench for fpu_wb_write_checker: event-time reference model compared every cycle, plus
// directed protocol scenarios with hand-computed expectations.
module tb_fpu_wb_write_checker;

  localparam int          NR      = 4;
  localparam int          CD      = 2;
  localparam int          TO      = 30000;
  localparam logic [15:0] C_START = 16'hAB60;
  localparam logic [15:0] C_PASS  = 16'hAB61;
  localparam logic [15:0] C_FIN   = 16'hAB62;
  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [3:0]  REQ     = 4'b1111;
  localparam logic [1:0]  ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3;

  logic         clk, rst, cyc, stb, we, ack;
  logic [31:0]  adr, dat;
  logic [127:0] reg_val;
  logic [15:0]  cb;
  logic [1:0]   state, idx;
  logic [15:0]  test_cnt, pass_cnt, fail_cnt;
  logic [3:0]   seen, mvec;
  logic         mis, done, tout;

  fpu_wb_write_checker dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs_cyc_i     (cyc),
    .wbs_stb_i     (stb),
    .wbs_we_i      (we),
    .wbs_ack_i     (ack),
    .wbs_adr_i     (adr),
    .wbs_dat_i     (dat),
    .reg_val_i     (reg_val),
    .checkbits_i   (cb),
    .state_o       (state),
    .test_cnt_o    (test_cnt),
    .pass_cnt_o    (pass_cnt),
    .fail_cnt_o    (fail_cnt),
    .regs_seen_o   (seen),
    .mismatch_vec_o(mvec),
    .mismatch_o    (mis),
    .mismatch_idx_o(idx),
    .all_done_o    (done),
    .timeout_o     (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;
  int last_ack, t_mark;
  int mis_pulses, mis_first, drain_cycles;

  always @(posedge clk) ncyc++;

  function automatic logic [31:0] reg_addr(input int k);
    case (k)
      0:       return BASE + 32'h00;
      1:       return BASE + 32'h04;
      2:       return BASE + 32'h1C;
      default: return BASE + 32'h24;
    endcase
  endfunction

  function automatic logic [15:0] bump(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Reference model: pending checks are absolute due-cycles, results are expected outputs.
  logic [1:0]  m_state, nxt, m_idx;
  logic [15:0] m_test, m_pass, m_fail, m_prev;
  logic [3:0]  m_seen, m_mvec, fails;
  logic        m_mis, m_done, m_to, model_valid = 1'b0;
  logic        ev_s, ev_p, ev_f, busy, judge, hs_ok, start_new;
  int          m_edge, m_elapsed;
  int          due [NR];
  logic [31:0] m_shadow [NR];

  always @(posedge clk) begin
    if (rst) begin
      {m_state, m_idx, m_test, m_pass, m_fail, m_prev} = '0;
      {m_seen, m_mvec, m_mis, m_done, m_to} = '0;
      m_edge = 0;
      m_elapsed = 0;
      for (int k = 0; k < NR; k++) begin
        due[k] = -1;
        m_shadow[k] = '0;
      end
      model_valid = 1'b1;
    end else begin
      m_edge++;
      ev_s = (cb == C_START) && (m_prev != C_START);
      ev_p = (cb == C_PASS) && (m_prev != C_PASS);
      ev_f = (cb == C_FIN) && (m_prev != C_FIN);
      m_prev = cb;
      fails = '0; busy = 0; judge = 0; hs_ok = 0; start_new = 0; m_mis = 0;
      nxt = m_state;
      if (m_state == ST_RUN || m_state == ST_DRAIN) begin
        for (int k = 0; k < NR; k++) begin
          if (due[k] >= 0) begin
            busy = 1;
            if (due[k] == m_edge) begin
              if (m_shadow[k] !== reg_val[k*32 +: 32]) fails[k] = 1'b1;
              due[k] = -1;
            end
          end
        end
      end
      m_mvec = m_mvec | fails;
      if (fails != 0) begin
        m_mis = 1;
        for (int k = NR - 1; k >= 0; k--) if (fails[k]) m_idx = 2'(k);
      end
      if (m_state != ST_DONE) begin
        m_elapsed++;
        if (ev_f) begin
          judge = (m_state == ST_DRAIN);
          m_done = 1;
          nxt = ST_DONE;
        end else if (m_elapsed == TO) begin
          m_to = 1;
          nxt = ST_DONE;
        end else if (m_state == ST_IDLE) begin
          start_new = ev_s;
        end else if (m_state == ST_RUN) begin
          if (ev_s) begin
            m_fail = bump(m_fail);
            start_new = 1;
          end else begin
            if (ev_p) begin
              if (busy) nxt = ST_DRAIN;
              else judge = 1;
            end
            hs_ok = 1;
          end
        end else begin
          judge = !busy;
        end
      end
      if (judge) begin
        if (m_mvec == 0 && (m_seen & REQ) == REQ) m_pass = bump(m_pass);
        else m_fail = bump(m_fail);
        if (nxt != ST_DONE) nxt = ST_IDLE;
      end
      if (hs_ok && cyc && stb && we && ack) begin
        for (int k = 0; k < NR; k++) begin
          if (adr == reg_addr(k)) begin
            m_shadow[k] = dat;
            m_seen[k] = 1'b1;
            due[k] = m_edge + CD;
          end
        end
      end
      if (start_new) begin
        m_test = bump(m_test);
        m_seen = '0;
        m_mvec = '0;
        for (int k = 0; k < NR; k++) due[k] = -1;
        nxt = ST_RUN;
      end
      m_state = nxt;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      n_tests++;
      if ({state, test_cnt, pass_cnt, fail_cnt, seen, mvec, mis, idx, done, tout} !==
          {m_state, m_test, m_pass, m_fail, m_seen, m_mvec, m_mis, m_idx, m_done, m_to}) begin
        n_fail++;
        $display("FAIL scoreboard cyc=%0d got st=%0d t/p/f=%0d/%0d/%0d seen=%b mv=%b mis=%b idx=%0d dn=%b to=%b want st=%0d t/p/f=%0d/%0d/%0d seen=%b mv=%b mis=%b idx=%0d dn=%b to=%b",
                 ncyc, state, test_cnt, pass_cnt, fail_cnt, seen, mvec, mis, idx, done, tout,
                 m_state, m_test, m_pass, m_fail, m_seen, m_mvec, m_mis, m_idx, m_done, m_to);
      end
    end
  end

  always @(negedge clk) begin
    if (mis === 1'b1) begin
      if (mis_pulses == 0) mis_first = ncyc;
      mis_pulses++;
    end
    if (state === ST_DRAIN) drain_cycles++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] code);
    cb = code;
    tick();
  endtask

  task automatic do_reset();
    cb = '0;
    reg_val = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mis_pulses = 0;
    mis_first = -1;
    drain_cycles = 0;
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d);
    cyc = 1; stb = 1; we = w; ack = 1; adr = a; dat = d;
    tick();
    cyc = 0; stb = 0; we = 0; ack = 0;
  endtask

  // Acked write; the FPU register reflects `mirror` from the following cycle.
  task automatic wr(input int k, input logic [31:0] d, input logic [31:0] mirror);
    bus(1'b1, reg_addr(k), d);
    last_ack = ncyc;
    reg_val[k*32 +: 32] = mirror;
  endtask

  initial begin
    rst = 1'b1; cb = '0; reg_val = '0;
    cyc = 0; stb = 0; we = 0; ack = 0; adr = '0; dat = '0;
    tick();

    // Matching writes, with a rewrite of reg 2 and ignored read/unmapped accesses.
    do_reset();
    send(C_START);
    wr(0, 32'h4080_0000, 32'h4080_0000);
    wr(1, 32'h0, 32'h0);
    wr(2, 32'h0000_1234, 32'h0);
    wr(2, 32'h0000_1005, 32'h0000_1005);
    wr(3, 32'h0, 32'h0);
    bus(1'b0, reg_addr(0), 32'hDEAD_BEEF);
    bus(1'b1, BASE + 32'h08, 32'h1);
    repeat (4) tick();
    send(C_PASS);
    repeat (3) tick();
    check("s1_test_cnt", test_cnt, 1);
    check("s1_pass_cnt", pass_cnt, 1);
    check("s1_fail_cnt", fail_cnt, 0);
    check("s1_no_mismatch", mis_pulses, 0);
    check("s1_state", state, ST_IDLE);

    // Forced mismatch on reg 2.
    do_reset();
    send(C_START);
    wr(0, 32'h4080_0000, 32'h4080_0000);
    wr(1, 32'h0, 32'h0);
    wr(2, 32'h0000_1005, 32'h0000_1004);
    t_mark = last_ack;
    wr(3, 32'h0, 32'h0);
    repeat (4) tick();
    send(C_PASS);
    repeat (3) tick();
    check("s2_pulses", mis_pulses, 1);
    check("s2_pulse_delay", 64'(mis_first + 1 - t_mark), CD + 1);
    check("s2_idx", idx, 2);
    check("s2_mvec", mvec, 4'b0100);
    check("s2_fail_cnt", fail_cnt, 1);
    check("s2_pass_cnt", pass_cnt, 0);

    // Missing rm write.
    do_reset();
    send(C_START);
    wr(0, 32'h4080_0000, 32'h4080_0000);
    wr(1, 32'h0, 32'h0);
    wr(2, 32'h0000_1005, 32'h0000_1005);
    repeat (4) tick();
    send(C_PASS);
    repeat (2) tick();
    check("s3_fail_cnt", fail_cnt, 1);
    check("s3_pass_cnt", pass_cnt, 0);
    check("s3_seen", seen, 4'b0111);

    // PASS while a check is pending drains first.
    do_reset();
    send(C_START);
    wr(2, 32'h0000_1005, 32'h0000_1005);
    wr(3, 32'h0, 32'h0);
    wr(0, 32'h4080_0000, 32'h4080_0000);
    wr(1, 32'h0, 32'h0);
    cb = C_PASS;
    repeat (5) tick();
    check("s4_drain_cycles", drain_cycles, 2);
    check("s4_pass_cnt", pass_cnt, 1);
    check("s4_state", state, ST_IDLE);

    // Completion; DONE ignores later codes.
    send(C_FIN);
    tick();
    check("s5_done", done, 1);
    check("s5_state", state, ST_DONE);
    send(C_START);
    tick();
    check("s5_state_held", state, ST_DONE);
    check("s5_test_held", test_cnt, 1);
    send(C_PASS);
    check("s5_pass_held", pass_cnt, 1);

    // Timeout after exactly TO cycles with no codes.
    do_reset();
    repeat (TO - 1) tick();
    check("s6_before_timeout", tout, 0);
    check("s6_before_state", state, ST_IDLE);
    tick();
    check("s6_timeout", tout, 1);
    check("s6_state", state, ST_DONE);

    // PASS held for 10 cycles counts once.
    do_reset();
    send(C_START);
    wr(0, 32'h4080_0000, 32'h4080_0000);
    wr(1, 32'h0, 32'h0);
    wr(2, 32'h0000_1005, 32'h0000_1005);
    wr(3, 32'h0, 32'h0);
    repeat (4) tick();
    cb = C_PASS;
    repeat (10) tick();
    check("s7_pass_once", pass_cnt, 1);
    check("s7_test_once", test_cnt, 1);

    // Reset mid-RUN clears everything.
    do_reset();
    send(C_START);
    wr(0, 32'h4080_0000, 32'h4080_0000);
    check("s8_run_seen", {state, seen}, {ST_RUN, 4'b0001});
    rst = 1'b1;
    tick();
    check("s8_rst_outputs",
          {state, test_cnt, pass_cnt, fail_cnt, seen, mvec, mis, idx, done, tout}, 64'd0);
    rst = 1'b0;

    // FINISH during DRAIN evaluates first.
    do_reset();
    send(C_START);
    wr(0, 32'h4080_0000, 32'h4080_0000);
    wr(1, 32'h0, 32'h0);
    wr(2, 32'h0000_1005, 32'h0000_1005);
    wr(3, 32'h0, 32'h0);
    send(C_PASS);
    check("s9_in_drain", state, ST_DRAIN);
    send(C_FIN);
    check("s9_pass_cnt", pass_cnt, 1);
    check("s9_done_state", {done, state}, {1'b1, ST_DONE});

    // FINISH on the timeout cycle wins.
    do_reset();
    repeat (TO - 1) tick();
    send(C_FIN);
    check("s10_done", done, 1);
    check("s10_no_timeout", tout, 0);
    check("s10_state", state, ST_DONE);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_wb_write_checker.md
Name: fpu_wb_write_checker

Overview:
- Synthesizable, parametrised Wishbone write-checker for the FPU user project; runs alongside the FPU slave on the user-project Wishbone bus.
- Generalises the FPU register-write checking to N registers with programmable offsets, compare delay and timeout.
- Tracks the firmware test protocol via the 16-bit checkbits word (start/pass/finish codes) and verifies each acknowledged write landed in the FPU register.
- Exports pass/fail/test counters and sticky mismatch status for GL/RTL benches and on-chip self-test.

Parameters:
- NUM_REGS, 4, number of checked FPU registers
- DATA_W, 32, register/data width
- ADDR_BASE, 32'h3000_0000, FPU slave base address
- REG_OFFSETS, {8'h24,8'h1C,8'h04,8'h00}, packed byte offsets; entry k at [8k+7:8k]
- REQ_MASK, 4'b1111, registers that must be written for a test to pass
- CHECK_DELAY, 2, cycles from write ack to compare (1..15)
- START_CODE / PASS_CODE / FINISH_CODE, 16'hAB60 / 16'hAB61 / 16'hAB62, checkbits codes
- TIMEOUT_CYCLES, 30000, cycles before timeout (fits 20-bit counter)

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  observed bus controls
- wbs_ack_i  in  1  observed slave ack
- wbs_adr_i  in  32  observed address
- wbs_dat_i  in  DATA_W  observed write data
- reg_val_i  in  NUM_REGS*DATA_W  FPU register values, zero-extended; slice k = register k
- checkbits_i  in  16  firmware status word
- state_o  out  2  0=IDLE 1=RUN 2=DRAIN 3=DONE
- test_cnt_o, pass_cnt_o, fail_cnt_o  out  16 each  saturating counters
- regs_seen_o  out  NUM_REGS  registers written in current test
- mismatch_vec_o  out  NUM_REGS  sticky per-test mismatch flags
- mismatch_o  out  1  one-cycle pulse on any compare failure
- mismatch_idx_o  out  $clog2(NUM_REGS)  lowest failing index of last pulse
- all_done_o, timeout_o  out  1 each  sticky completion flags

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset wb_rst_i is synchronous, active-high.
- Reset values: all outputs, counters, pending timers and prev_checkbits are 0; state IDLE.
- Code events: checkbits_i is registered into prev_checkbits. An event is checkbits_i == CODE while prev_checkbits != CODE, so each code counts once.
- Write handshake: wbs_cyc_i & wbs_stb_i & wbs_we_i & wbs_ack_i with wbs_adr_i == ADDR_BASE + REG_OFFSETS[k]. Non-matching addresses and reads are ignored.
- IDLE: START event -> RUN; test_cnt++, regs_seen and mismatch_vec cleared.
- RUN, on a handshake to k:
  - Captures data into shadow[k], sets regs_seen[k], loads timer[k] = CHECK_DELAY.
  - Timer decrements each cycle. At 0, compares shadow[k] vs reg_val_i slice k; a mismatch sets mismatch_vec[k] and pulses mismatch_o the next cycle.
  - A rewrite of k while pending restarts the timer with new data (last write wins).
  - Registers are independent; simultaneous failures report the lowest index in mismatch_idx_o.
- RUN, PASS event: -> DRAIN if any timer nonzero, else evaluate the same cycle.
- DRAIN: waits for all timers to reach 0, then evaluates and returns to IDLE.
- Evaluation: pass iff mismatch_vec == 0 and (regs_seen & REQ_MASK) == REQ_MASK. Increments pass_cnt or fail_cnt, then IDLE. regs_seen and mismatch_vec hold until the next START.
- START event in RUN: current test counted as fail, then a new test begins.
- FINISH event in any state except DONE: all_done_o=1, state DONE. A FINISH event in DRAIN first completes the evaluation.
- Timeout: cycle counter runs in IDLE/RUN/DRAIN from reset. Reaching TIMEOUT_CYCLES sets timeout_o=1 and state DONE. Timeout and FINISH in the same cycle: FINISH wins, timeout_o stays 0.
- DONE is absorbing until reset. Counters saturate at 16'hFFFF.
- Reset mid-test discards pending checks with no count update.

Test Plan:
- Start and writes, matching regs: AB60, then writes a=32'h4080_0000, b=0, op=32'h0000_1005, rm=0, with reg_val_i mirroring them 1 cycle after ack; then AB61 -> test_cnt=1, pass_cnt=1, mismatch_o never asserted.
- Forced mismatch: same sequence with reg_val_i slice 2 = 32'h0000_1004 -> mismatch_o pulse exactly CHECK_DELAY+1 cycles after ack, mismatch_idx_o=2, fail_cnt=1.
- Missing write: omit rm write, then AB61 -> fail_cnt=1, regs_seen_o=4'b0111.
- Drain: AB61 one cycle after the b ack -> state_o=2 for 2 cycles, then pass_cnt increments and state_o=0.
- Completion and timeout: AB62 -> all_done_o=1, state_o=3, later codes ignored. No codes for 30000 cycles -> timeout_o=1.
- Code stuck and reset: checkbits held at AB61 for 10 cycles counts once. wb_rst_i mid-RUN -> all outputs 0 the next cycle.
